// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite initiator: response codes and FSM state encoding.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [5:0] {
      ST_IDLE    = 6'b000001,
      ST_WR_REQ  = 6'b000010,
      ST_WR_RESP = 6'b000100,
      ST_RD_REQ  = 6'b001000,
      ST_RD_RESP = 6'b010000,
      ST_DONE    = 6'b100000
   } state_t;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AW/W/B or AR/R
// transaction out, one-cycle result pulse back.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// WR_REQ  | AW and W presented; each drops on its own handshake
// WR_RESP | BREADY high, waiting for BVALID
// RD_REQ  | ARVALID high, waiting for ARREADY
// RD_RESP | RREADY high, waiting for RVALID
// DONE    | rsp_valid pulse, then back to IDLE
module axi_lite_master
   import axi_lite_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_wstrb,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic [1:0]          rsp_resp,
   output logic [ADDR_W-1:0]   AWADDR,
   output logic                AWVALID,
   input  logic                AWREADY,
   output logic [DATA_W-1:0]   WDATA,
   output logic [DATA_W/8-1:0] WSTRB,
   output logic                WVALID,
   input  logic                WREADY,
   input  logic [1:0]          BRESP,
   input  logic                BVALID,
   output logic                BREADY,
   output logic [ADDR_W-1:0]   ARADDR,
   output logic                ARVALID,
   input  logic                ARREADY,
   input  logic [DATA_W-1:0]   RDATA,
   input  logic [1:0]          RRESP,
   input  logic                RVALID,
   output logic                RREADY
);

   state_t state;
   logic   aw_done;
   logic   w_done;
   logic   aw_fire;
   logic   w_fire;
   logic   wr_req_done;

   assign aw_fire     = AWVALID & AWREADY;
   assign w_fire      = WVALID & WREADY;
   assign wr_req_done = (aw_done | aw_fire) & (w_done | w_fire);

   // All outputs are registered and set from the state being entered, so no
   // READY/VALID input ever reaches an output combinationally.
   always_ff @(posedge ACLK or negedge ARESET) begin
      if (!ARESET) begin
         state     <= ST_IDLE;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_resp  <= RESP_OKAY;
         AWADDR    <= '0;
         AWVALID   <= 1'b0;
         WDATA     <= '0;
         WSTRB     <= '0;
         WVALID    <= 1'b0;
         BREADY    <= 1'b0;
         ARADDR    <= '0;
         ARVALID   <= 1'b0;
         RREADY    <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  if (cmd_write) begin
                     AWADDR  <= cmd_addr;
                     WDATA   <= cmd_wdata;
                     WSTRB   <= cmd_wstrb;
                     AWVALID <= 1'b1;
                     WVALID  <= 1'b1;
                     state   <= ST_WR_REQ;
                  end else begin
                     ARADDR  <= cmd_addr;
                     ARVALID <= 1'b1;
                     state   <= ST_RD_REQ;
                  end
               end
            end
            ST_WR_REQ: begin
               if (aw_fire) begin
                  AWVALID <= 1'b0;
                  aw_done <= 1'b1;
               end
               if (w_fire) begin
                  WVALID <= 1'b0;
                  w_done <= 1'b1;
               end
               if (wr_req_done) begin
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
                  BREADY  <= 1'b1;
                  state   <= ST_WR_RESP;
               end
            end
            ST_WR_RESP: begin
               if (BVALID) begin
                  BREADY    <= 1'b0;
                  rsp_resp  <= BRESP;
                  rsp_valid <= 1'b1;
                  state     <= ST_DONE;
               end
            end
            ST_RD_REQ: begin
               if (ARREADY) begin
                  ARVALID <= 1'b0;
                  RREADY  <= 1'b1;
                  state   <= ST_RD_RESP;
               end
            end
            ST_RD_RESP: begin
               if (RVALID) begin
                  RREADY    <= 1'b0;
                  rsp_rdata <= RDATA;
                  rsp_resp  <= RRESP;
                  rsp_valid <= 1'b1;
                  state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               cmd_ready <= 1'b1;
               state     <= ST_IDLE;
            end
            default: begin
               cmd_ready <= 1'b0;
               AWVALID   <= 1'b0;
               WVALID    <= 1'b0;
               BREADY    <= 1'b0;
               ARVALID   <= 1'b0;
               RREADY    <= 1'b0;
               aw_done   <= 1'b0;
               w_done    <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a delay-programmable AXI4-Lite target, a byte-level
// memory reference model and a scoreboard monitor on the result port.
module tb_axi_lite_master;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [31:0] AWADDR;
   logic        AWVALID;
   logic        AWREADY = 1'b0;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WVALID;
   logic        WREADY = 1'b0;
   logic [1:0]  BRESP = '0;
   logic        BVALID = 1'b0;
   logic        BREADY;
   logic [31:0] ARADDR;
   logic        ARVALID;
   logic        ARREADY = 1'b0;
   logic [31:0] RDATA = '0;
   logic [1:0]  RRESP = '0;
   logic        RVALID = 1'b0;
   logic        RREADY;

   always #5 ACLK = ~ACLK;

   axi_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
   );

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [1:0]  resp;
      int          aw_d, w_d, b_d, ar_d, r_d;
      bit          early_b;
   } txn_t;

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  resp;
      int          lat;
   } exp_t;

   txn_t        slv_q[$];
   exp_t        exp_q[$];
   logic [31:0] ref_mem[8];
   logic [31:0] slv_mem[8];
   logic [31:0] last_rd;
   int          checks = 0, errors = 0, cyc = 0;
   int          inflight = 0, rsp_cnt = 0, n_issued = 0, acc_cyc = 0;

   always @(posedge ACLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic summary();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
   endtask

   function automatic txn_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input logic [1:0] resp,
                               input int awd, input int wd, input int bd,
                               input int ard, input int rd, input bit eb);
      txn_t t;
      t.wr = wr; t.addr = addr; t.wdata = data; t.wstrb = strb; t.resp = resp;
      t.aw_d = awd; t.w_d = wd; t.b_d = bd; t.ar_d = ard; t.r_d = rd;
      t.early_b = eb & wr;
      return t;
   endfunction

   // Reference: byte-enabled memory, result data holds the last read, latency
   // is three cycles plus every stall the target inserts.
   task automatic model(input txn_t t, output exp_t e);
      int i;
      i = int'(t.addr[4:2]);
      e.resp = t.resp;
      if (t.wr) begin
         for (int b = 0; b < 4; b++)
            if (t.wstrb[b]) ref_mem[i][8*b +: 8] = t.wdata[8*b +: 8];
         e.rdata = last_rd;
         e.lat = 3 + ((t.aw_d > t.w_d) ? t.aw_d : t.w_d) + (t.early_b ? 0 : t.b_d);
      end else begin
         e.rdata = ref_mem[i];
         last_rd = e.rdata;
         e.lat = 3 + t.ar_d + t.r_d;
      end
   endtask

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic issue(input txn_t t, output int acc);
      exp_t e;
      int   n;
      model(t, e);
      slv_q.push_back(t);
      exp_q.push_back(e);
      n_issued++;
      cmd_write = t.wr;
      cmd_addr  = t.addr;
      cmd_wdata = t.wdata;
      cmd_wstrb = t.wstrb;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 200) begin
         @(negedge ACLK);
         n++;
      end
      if (!cmd_ready) begin
         errors++;
         $display("FAIL accept_timeout: cmd_ready still %0b after %0d cycles", cmd_ready, n);
         summary();
         $fatal(1);
      end
      acc = cyc;
      @(negedge ACLK);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge ACLK);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL idle_timeout: %0d responses outstanding", exp_q.size());
      end
   endtask

   // Scoreboard monitor, sampled after the falling-edge drives have settled.
   initial begin
      exp_t e;
      bit   prev_rsp;
      prev_rsp = 1'b0;
      forever begin
         @(negedge ACLK);
         #2;
         if (!ARESET) begin
            prev_rsp = 1'b0;
         end else begin
            if (cmd_valid && cmd_ready) begin
               chk("no_overlap", 64'(inflight), 64'd0);
               inflight++;
               acc_cyc = cyc;
            end
            if (rsp_valid) begin
               chk("single_pulse", 64'(prev_rsp), 64'd0);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_rsp: rsp_valid with nothing outstanding");
               end else begin
                  e = exp_q.pop_front();
                  chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                  chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
                  chk("latency", 64'(cyc - acc_cyc), 64'(e.lat));
                  inflight--;
                  rsp_cnt++;
               end
            end
            prev_rsp = rsp_valid;
         end
      end
   end

   // Target model: drives at falling edges, applies handshakes from the
   // previous rising edge, and polices VALID stability.
   initial begin
      txn_t        cur;
      bit          have, aw_got, w_got, ar_got;
      int          aw_w, w_w, b_w, ar_w, r_w;
      logic [2:0]  aw_idx, ar_idx;
      logic [31:0] w_data_s;
      logic [3:0]  w_strb_s;
      bit          p_aw_hs, p_w_hs, p_b_hs, p_ar_hs, p_r_hs, p_awv, p_wv, p_arv;
      logic [31:0] p_awaddr, p_wdata, p_araddr;
      logic [3:0]  p_wstrb;
      have = 0; aw_got = 0; w_got = 0; ar_got = 0;
      aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0;
      aw_idx = '0; ar_idx = '0; w_data_s = '0; w_strb_s = '0;
      p_aw_hs = 0; p_w_hs = 0; p_b_hs = 0; p_ar_hs = 0; p_r_hs = 0;
      p_awv = 0; p_wv = 0; p_arv = 0; p_awaddr = '0; p_wdata = '0; p_araddr = '0; p_wstrb = '0;
      cur = mk(0, '0, '0, '0, '0, 0, 0, 0, 0, 0, 0);
      forever begin
         @(negedge ACLK);
         if (!ARESET) begin
            have = 0; aw_got = 0; w_got = 0; ar_got = 0;
            p_aw_hs = 0; p_w_hs = 0; p_b_hs = 0; p_ar_hs = 0; p_r_hs = 0;
            p_awv = 0; p_wv = 0; p_arv = 0;
            AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
         end else begin
            if (p_aw_hs) begin
               aw_got = 1; AWREADY = 0; aw_idx = p_awaddr[4:2];
               chk("awaddr", 64'(p_awaddr), 64'(cur.addr));
            end
            if (p_w_hs) begin
               w_got = 1; WREADY = 0; w_data_s = p_wdata; w_strb_s = p_wstrb;
            end
            if ((p_aw_hs || p_w_hs) && aw_got && w_got)
               for (int b = 0; b < 4; b++)
                  if (w_strb_s[b]) slv_mem[aw_idx][8*b +: 8] = w_data_s[8*b +: 8];
            if (p_b_hs) begin BVALID = 0; have = 0; end
            if (p_ar_hs) begin
               ar_got = 1; ARREADY = 0; ar_idx = p_araddr[4:2];
               chk("araddr", 64'(p_araddr), 64'(cur.addr));
            end
            if (p_r_hs) begin RVALID = 0; have = 0; end

            if (p_aw_hs) chk("awvalid_drop", 64'(AWVALID), 64'd0);
            else if (p_awv) chk("aw_stable", {31'd0, AWVALID, AWADDR}, {31'd0, 1'b1, p_awaddr});
            if (p_w_hs) chk("wvalid_drop", 64'(WVALID), 64'd0);
            else if (p_wv) chk("w_stable", {27'd0, WVALID, WSTRB, WDATA}, {27'd0, 1'b1, p_wstrb, p_wdata});
            if (p_ar_hs) chk("arvalid_drop", 64'(ARVALID), 64'd0);
            else if (p_arv) chk("ar_stable", {31'd0, ARVALID, ARADDR}, {31'd0, 1'b1, p_araddr});
            if (AWVALID || WVALID) chk("bready_low_in_req", 64'(BREADY), 64'd0);

            if (!have && (AWVALID || WVALID || ARVALID)) begin
               if (slv_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_txn: AXI request with no command queued");
               end else begin
                  cur = slv_q.pop_front();
                  have = 1; aw_got = 0; w_got = 0; ar_got = 0;
                  aw_w = cur.aw_d; w_w = cur.w_d; b_w = cur.b_d; ar_w = cur.ar_d; r_w = cur.r_d;
                  chk("txn_kind", 64'(ARVALID), 64'(!cur.wr));
                  if (cur.early_b) begin BVALID = 1; BRESP = cur.resp; end
               end
            end

            if (have && cur.wr) begin
               if (!aw_got && AWVALID) begin
                  if (aw_w == 0) AWREADY = 1; else aw_w--;
               end
               if (!w_got && WVALID) begin
                  if (w_w == 0) WREADY = 1; else w_w--;
               end
               if (aw_got && w_got && !BVALID) begin
                  if (b_w == 0) begin BVALID = 1; BRESP = cur.resp; end else b_w--;
               end
            end
            if (have && !cur.wr) begin
               if (!ar_got && ARVALID) begin
                  if (ar_w == 0) ARREADY = 1; else ar_w--;
               end
               if (ar_got && !RVALID) begin
                  if (r_w == 0) begin
                     RVALID = 1; RDATA = slv_mem[ar_idx]; RRESP = cur.resp;
                  end else r_w--;
               end
            end

            p_aw_hs = AWVALID && AWREADY;
            p_w_hs  = WVALID && WREADY;
            p_b_hs  = BVALID && BREADY;
            p_ar_hs = ARVALID && ARREADY;
            p_r_hs  = RVALID && RREADY;
            p_awv = AWVALID; p_awaddr = AWADDR;
            p_wv = WVALID; p_wdata = WDATA; p_wstrb = WSTRB;
            p_arv = ARVALID; p_araddr = ARADDR;
         end
      end
   end

   initial begin
      #400000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      summary();
      $fatal(1);
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_handshakes"}, {57'd0, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, cmd_ready}, 64'd0);
      chk({tag, "_addr"}, {AWADDR, ARADDR}, 64'd0);
      chk({tag, "_wdata"}, {28'd0, WSTRB, WDATA}, 64'd0);
      chk({tag, "_rsp"}, {30'd0, rsp_resp, rsp_rdata}, 64'd0);
   endtask

   initial begin
      txn_t t;
      int   a1, a2, n;
      for (int i = 0; i < 8; i++) begin
         ref_mem[i] = '0;
         slv_mem[i] = '0;
      end
      last_rd = '0;

      repeat (2) @(negedge ACLK);
      #1;
      chk_reset_outputs("reset");
      ARESET = 1'b1;
      chk("cmd_ready_at_release", 64'(cmd_ready), 64'd0);
      @(negedge ACLK);
      chk("cmd_ready_after_release", 64'(cmd_ready), 64'd1);

      // Zero-wait write then read-back of the same word.
      issue(mk(1, 32'h4, 32'hA5A5_1234, 4'hF, 2'b00, 0, 0, 0, 0, 0, 0), a1);
      issue(mk(0, 32'h4, '0, '0, 2'b00, 0, 0, 0, 0, 0, 0), a1);
      cmd_valid = 1'b0;
      wait_idle();
      chk("readback_byte0", 64'(rsp_rdata[7:0]), 64'h34);

      // W accepted five cycles after AW.
      issue(mk(1, 32'h8, 32'h1357_9BDF, 4'hF, 2'b00, 0, 5, 0, 0, 0, 0), a1);
      cmd_valid = 1'b0;
      wait_idle();

      // BVALID raised early with SLVERR.
      issue(mk(1, 32'hC, 32'h0BAD_F00D, 4'h5, 2'b10, 2, 1, 0, 0, 0, 1), a1);
      cmd_valid = 1'b0;
      wait_idle();

      // Read with RVALID three cycles late.
      issue(mk(1, 32'h10, 32'hDEAD_BEEF, 4'hF, 2'b00, 0, 0, 0, 0, 0, 0), a1);
      issue(mk(0, 32'h10, '0, '0, 2'b00, 0, 0, 0, 0, 3, 0), a1);
      cmd_valid = 1'b0;
      wait_idle();

      // cmd_valid held across two zero-wait commands.
      issue(mk(1, 32'h18, 32'h0000_00AA, 4'h1, 2'b01, 0, 0, 0, 0, 0, 0), a1);
      issue(mk(0, 32'h18, '0, '0, 2'b11, 0, 0, 0, 0, 0, 0), a2);
      cmd_valid = 1'b0;
      chk("throughput", 64'(a2 - a1), 64'd4);
      wait_idle();

      // Reset while the write waits for its response.
      issue(mk(1, 32'h14, 32'hCAFE_0001, 4'hF, 2'b00, 0, 0, 5, 0, 0, 0), a1);
      cmd_valid = 1'b0;
      n = 0;
      while (!BREADY && n < 50) begin
         @(negedge ACLK);
         n++;
      end
      chk("reached_wr_resp", 64'(BREADY), 64'd1);
      #1;
      ARESET = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      exp_q.delete();
      slv_q.delete();
      inflight = 0;
      n_issued--;
      last_rd = '0;
      repeat (2) @(negedge ACLK);
      #1;
      ARESET = 1'b1;
      chk("cmd_ready_at_rerelease", 64'(cmd_ready), 64'd0);
      @(negedge ACLK);
      chk("cmd_ready_after_rerelease", 64'(cmd_ready), 64'd1);
      issue(mk(0, 32'h14, '0, '0, 2'b00, 0, 0, 0, 1, 0, 0), a1);
      cmd_valid = 1'b0;
      wait_idle();

      // Randomized traffic with random stalls and idle gaps.
      for (int i = 0; i < 40; i++) begin
         t = mk($urandom_range(0, 1) == 1,
                ($urandom & 32'hFFFF_FFE0) | (32'($urandom_range(0, 7)) << 2),
                $urandom, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) == 0);
         issue(t, a1);
         if ($urandom_range(0, 2) == 0) begin
            cmd_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge ACLK);
         end
      end
      cmd_valid = 1'b0;
      wait_idle();
      repeat (3) @(negedge ACLK);
      chk("rsp_count", 64'(rsp_cnt), 64'(n_issued));

      summary();
      $finish;
   end

endmodule
